// File: rtl/tx_buffer.sv
// tx_buffer: holds up to NUM_SEQ sorted arrays and, on flush, streams them
// out byte-wise to the UART transmitter (word 0 byte 0 first, little-endian).
module tx_buffer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_SEQ = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [WIDTH*DEPTH-1:0]   array_in,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     overflow,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     done
);

    localparam int BYTES = WIDTH / 8;
    localparam int BW    = (BYTES   > 1) ? $clog2(BYTES)   : 1;
    localparam int WW    = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;
    localparam int AW    = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
    localparam int CW    = $clog2(NUM_SEQ + 1);

    typedef enum logic {
        LOADING,
        SENDING
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_rd_arr;
    logic [WW-1:0]     r_rd_word;
    logic [BW-1:0]     r_rd_byte;
    logic              r_overflow;
    logic              r_done;

    logic [WIDTH-1:0]  r_mem [NUM_SEQ][DEPTH];

    logic              w_accept;
    logic              w_xfer;
    logic              w_byte_last;
    logic              w_word_last;
    logic              w_arr_last;
    logic              w_batch_last;
    logic [WIDTH-1:0]  w_word;
    logic [7:0]        w_byte;

    assign in_ready     = (r_state == LOADING) && (r_count < CW'(NUM_SEQ));
    assign w_accept     = valid_in && in_ready;
    assign byte_valid   = (r_state == SENDING);
    assign w_xfer       = byte_valid && byte_ready;
    assign w_byte_last  = (r_rd_byte == BW'(BYTES - 1));
    assign w_word_last  = (r_rd_word == WW'(DEPTH - 1));
    assign w_arr_last   = ((CW'(r_rd_arr) + CW'(1)) == r_count);
    assign w_batch_last = w_xfer && w_byte_last && w_word_last && w_arr_last;
    assign overflow     = r_overflow;
    assign done         = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOADING;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a flush only starts a batch when something is (or is being) stored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOADING: begin
                if (flush && ((r_count != '0) || w_accept)) begin
                    w_state_next = SENDING;
                end
            end
            SENDING: begin
                if (w_batch_last) begin
                    w_state_next = LOADING;
                end
            end
            default: w_state_next = LOADING;
        endcase
    end

    // Count, read indices and the one-cycle overflow/done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_arr   <= '0;
            r_rd_word  <= '0;
            r_rd_byte  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_overflow <= valid_in && !in_ready;
            r_done     <= 1'b0;
            case (r_state)
                LOADING: begin
                    if (w_accept) begin
                        r_count <= r_count + CW'(1);
                    end
                    if (flush && (r_count == '0) && !w_accept) begin
                        r_done <= 1'b1;
                    end
                end
                SENDING: begin
                    if (w_xfer) begin
                        if (!w_byte_last) begin
                            r_rd_byte <= r_rd_byte + BW'(1);
                        end else begin
                            r_rd_byte <= '0;
                            if (!w_word_last) begin
                                r_rd_word <= r_rd_word + WW'(1);
                            end else begin
                                r_rd_word <= '0;
                                if (w_arr_last) begin
                                    r_rd_arr <= '0;
                                    r_count  <= '0;
                                    r_done   <= 1'b1;
                                end else begin
                                    r_rd_arr <= r_rd_arr + AW'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Array storage; write slot is the current count. Contents are not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned s = 0; s < NUM_SEQ; s++) begin
                if (r_count == CW'(s)) begin
                    for (int unsigned w = 0; w < DEPTH; w++) begin
                        r_mem[s][w] <= array_in[w*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Byte select from the current word, driven only by registered indices.
    always_comb begin
        w_word = r_mem[r_rd_arr][r_rd_word];
        w_byte = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_rd_byte == BW'(b)) begin
                w_byte = w_word[8*b +: 8];
            end
        end
    end

    // Output byte is forced to zero whenever it is not valid.
    always_comb begin
        byte_out = byte_valid ? w_byte : '0;
    end

endmodule

// File: tb/tb_tx_buffer.sv
// tb_tx_buffer: directed + randomized checks of tx_buffer against a byte-queue model.
module tb_tx_buffer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NUM_SEQ = 10;
    localparam int BYTES   = WIDTH / 8;
    localparam int WD      = WIDTH * DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic [WD-1:0] array_in = '0;
    logic          flush = 1'b0;
    logic          in_ready;
    logic          overflow;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic          done;

    int            vectors = 0;
    int            miscompares = 0;
    logic [7:0]    exp_q[$];
    int            mcount = 0;

    tx_buffer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NUM_SEQ (NUM_SEQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .array_in   (array_in),
        .flush      (flush),
        .in_ready   (in_ready),
        .overflow   (overflow),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WD-1:0] rand_array();
        logic [WD-1:0] a;
        for (int w = 0; w < DEPTH; w++) a[w*WIDTH +: WIDTH] = $urandom;
        return a;
    endfunction

    function automatic logic [WD-1:0] ramp_array();
        logic [WD-1:0] a;
        for (int k = 0; k < DEPTH; k++)
            a[k*WIDTH +: WIDTH] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        return a;
    endfunction

    // Offer one array; model accepts it only while fewer than NUM_SEQ are held.
    task automatic load(input logic [WD-1:0] a, input bit with_flush);
        bit acc;
        acc = (mcount < NUM_SEQ);
        array_in = a;
        valid_in = 1'b1;
        flush    = with_flush;
        chk("in_ready", in_ready, acc);
        tick();
        valid_in = 1'b0;
        flush    = 1'b0;
        if (acc) begin
            for (int w = 0; w < DEPTH; w++)
                for (int b = 0; b < BYTES; b++)
                    exp_q.push_back(a[w*WIDTH + 8*b +: 8]);
            mcount++;
        end
        chk("overflow", overflow, !acc);
        if (with_flush) begin
            chk("sending_after_flush", byte_valid, 1);
            mcount = 0;
        end
    endtask

    task automatic do_flush();
        bit empty;
        empty = (mcount == 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_byte_valid", byte_valid, !empty);
        chk("flush_done", done, empty);
        mcount = 0;
    endtask

    // Drain the model queue with byte_ready high ready_pct% of cycles.
    task automatic drain(input int ready_pct, input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            byte_ready = ($urandom_range(99) < ready_pct);
            chk("byte_valid", byte_valid, 1);
            chk("byte_out", byte_out, exp_q[0]);
            chk("done_busy", done, 0);
            tick();
            cycles++;
            if (byte_ready) void'(exp_q.pop_front());
        end
        byte_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        chk("done_end", done, 1);
        chk("byte_valid_end", byte_valid, 0);
        chk("byte_out_end", byte_out, 0);
        chk("in_ready_end", in_ready, 1);
        tick();
        chk("done_pulse_1cyc", done, 0);
    endtask

    initial begin
        int cyc;

        // 1: reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();
        chk("idle_done", done, 0);

        // 2: ramp array, full-rate drain, exact throughput
        load(ramp_array(), 1'b0);
        do_flush();
        drain(100, 100, cyc);
        chk("ramp_cycles", cyc, 32);

        // 3: ramp array with random stalls
        load(ramp_array(), 1'b0);
        do_flush();
        drain(50, 1000, cyc);

        // 4: fill, overflow on the 11th, then 320 bytes in load order
        for (int i = 0; i < NUM_SEQ; i++) load(rand_array(), 1'b0);
        chk("full_in_ready", in_ready, 0);
        load(rand_array(), 1'b0);
        tick();
        chk("overflow_cleared", overflow, 0);
        do_flush();
        drain(80, 3000, cyc);

        // 5: empty flush
        do_flush();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_done_gone", done, 0);
            chk("empty_no_bytes", byte_valid, 0);
        end

        // valid_in with flush in the same cycle joins the batch; valid_in while sending overflows
        load(rand_array(), 1'b0);
        load(rand_array(), 1'b1);
        byte_ready = 1'b0;
        valid_in   = 1'b1;
        array_in   = rand_array();
        chk("sending_in_ready", in_ready, 0);
        tick();
        valid_in = 1'b0;
        chk("sending_overflow", overflow, 1);
        chk("stall_byte_out", byte_out, exp_q[0]);
        drain(70, 1000, cyc);

        // 6: reset mid-batch, then a fresh batch starts at its own byte 0
        load(rand_array(), 1'b0);
        do_flush();
        byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("pre_rst_byte", byte_out, exp_q[0]);
            tick();
            void'(exp_q.pop_front());
        end
        byte_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mcount = 0;
        chk("abort_byte_valid", byte_valid, 0);
        chk("abort_byte_out", byte_out, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_done", done, 0);
        tick();
        chk("abort_idle", byte_valid, 0);
        load(rand_array(), 1'b0);
        do_flush();
        drain(100, 100, cyc);
        chk("post_rst_cycles", cyc, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
